alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 44 ++++
 rtl/alu_arb_rr.sv | 66 ++++++
 rtl/alu_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - requester count and datapath widths
//   - FSM state encoding (IDLE -> EXEC -> RESP)
//   - latched operation record handed from the winner mux to the ALU drive regs
//   - one-hot helper used for ready/valid strobes
// -----------------------------------------------------------------------------
package alu_arb_pkg;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned FLAG_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } arb_state_t;

   // Everything the ALU needs for one operation, plus the lock request bit.
   typedef struct packed {
      logic [DATA_W-1:0] src_a;
      logic [DATA_W-1:0] src_b;
      logic [OP_W-1:0]   control;
      logic              carry;
      logic              carry_use;
      logic              reverse_b;
      logic              chain;
   } alu_op_t;

   // Requester index to one-hot strobe.
   function automatic logic [NUM_REQ-1:0] onehot2(input logic idx);
      logic [NUM_REQ-1:0] vec;
      if (idx) begin
         vec = 2'b10;
      end else begin
         vec = 2'b01;
      end
      return vec;
   endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// -----------------------------------------------------------------------------
// alu_arb_rr
// Purely combinational arbitration for the ALU arbiter.
//   PRIO_FIXED   0 = round-robin, 1 = requester 0 wins when both eligible
//   req_valid    per-requester request
//   lock_active  a chained sequence owns the ALU
//   lock_owner   requester holding the lock
//   last_grant   requester accepted most recently
//   grant_valid  some requester is eligible this cycle
//   grant_idx    index of the winning requester
// -----------------------------------------------------------------------------
module alu_arb_rr
   import alu_arb_pkg::*;
#(
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               lock_active,
   input  logic               lock_owner,
   input  logic               last_grant,
   output logic               grant_valid,
   output logic               grant_idx
);

   logic [NUM_REQ-1:0] eligible_s;

   // Mask out the non-owner while a chained sequence holds the lock.
   always_comb begin
      eligible_s = req_valid;
      if (lock_active) begin
         eligible_s = req_valid & onehot2(lock_owner);
      end else begin
         eligible_s = req_valid;
      end
   end

   // Pick the winner among eligible requesters.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
      case (eligible_s)
         2'b01: begin
            grant_valid = 1'b1;
            grant_idx   = 1'b0;
         end
         2'b10: begin
            grant_valid = 1'b1;
            grant_idx   = 1'b1;
         end
         2'b11: begin
            grant_valid = 1'b1;
            // Round-robin hands the contested slot to whoever did not go last.
            if (PRIO_FIXED) begin
               grant_idx = 1'b0;
            end else begin
               grant_idx = ~last_grant;
            end
         end
         default: begin
            grant_valid = 1'b0;
            grant_idx   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters.
// One operation at a time: IDLE (accept) -> EXEC (drive ALU, capture result)
// -> RESP (hold response until the owner accepts it).
//   CLK, Reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is same-cycle)
//   req_src_a/b           operands, requester i at [32i+31:32i]
//   req_alu_control       opcode, requester i at [3i+2:3i]
//   req_carry/_carry_use/_reverse_b/_chain   per-requester control bits
//   alu_*                 drive to the ALU (zero while idle)
//   alu_result/alu_flags  ALU outputs {N,Z,C,V}
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_result/rsp_flags  captured ALU outputs
//   grant_id              current owner, busy = not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic                       CLK,
   input  logic                       Reset_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]  req_src_a,
   input  logic [NUM_REQ*DATA_W-1:0]  req_src_b,
   input  logic [NUM_REQ*OP_W-1:0]    req_alu_control,
   input  logic [NUM_REQ-1:0]         req_carry,
   input  logic [NUM_REQ-1:0]         req_carry_use,
   input  logic [NUM_REQ-1:0]         req_reverse_b,
   input  logic [NUM_REQ-1:0]         req_chain,
   output logic [DATA_W-1:0]          alu_src_a,
   output logic [DATA_W-1:0]          alu_src_b,
   output logic [OP_W-1:0]            alu_control,
   output logic                       alu_carry,
   output logic                       alu_carry_use,
   output logic                       alu_reverse_b,
   input  logic [DATA_W-1:0]          alu_result,
   input  logic [FLAG_W-1:0]          alu_flags,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [DATA_W-1:0]          rsp_result,
   output logic [FLAG_W-1:0]          rsp_flags,
   output logic                       grant_id,
   output logic                       busy
);

   arb_state_t          state_r;
   arb_state_t          state_nxt_s;

   logic                grant_valid_s;
   logic                grant_idx_s;
   logic                accept_s;
   logic                capture_s;
   logic                release_s;
   logic [NUM_REQ-1:0]  req_ready_s;

   alu_op_t             req_op_s;
   alu_op_t             op_r;

   logic                lock_active_r;
   logic                lock_owner_r;
   logic                last_grant_r;
   logic                grant_id_r;
   logic                busy_r;

   logic [NUM_REQ-1:0]  rsp_valid_r;
   logic [DATA_W-1:0]   rsp_result_r;
   logic [FLAG_W-1:0]   rsp_flags_r;

   alu_arb_rr #(
      .PRIO_FIXED (PRIO_FIXED)
   ) u_arb (
      .req_valid   (req_valid),
      .lock_active (lock_active_r),
      .lock_owner  (lock_owner_r),
      .last_grant  (last_grant_r),
      .grant_valid (grant_valid_s),
      .grant_idx   (grant_idx_s)
   );

   // Gather the winning requester's operation fields.
   always_comb begin
      req_op_s = '0;
      if (grant_idx_s) begin
         req_op_s.src_a     = req_src_a[63:32];
         req_op_s.src_b     = req_src_b[63:32];
         req_op_s.control   = req_alu_control[5:3];
         req_op_s.carry     = req_carry[1];
         req_op_s.carry_use = req_carry_use[1];
         req_op_s.reverse_b = req_reverse_b[1];
         req_op_s.chain     = req_chain[1];
      end else begin
         req_op_s.src_a     = req_src_a[31:0];
         req_op_s.src_b     = req_src_b[31:0];
         req_op_s.control   = req_alu_control[2:0];
         req_op_s.carry     = req_carry[0];
         req_op_s.carry_use = req_carry_use[0];
         req_op_s.reverse_b = req_reverse_b[0];
         req_op_s.chain     = req_chain[0];
      end
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_valid_s) begin
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_nxt_s = ST_RESP;
         end
         ST_RESP: begin
            // Only the owner's ready can close the response.
            if (rsp_ready[grant_id_r]) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM output decode: ready strobe and datapath enables.
   always_comb begin
      accept_s    = 1'b0;
      capture_s   = 1'b0;
      release_s   = 1'b0;
      req_ready_s = 2'b00;
      case (state_r)
         ST_IDLE: begin
            accept_s = grant_valid_s;
            if (grant_valid_s) begin
               req_ready_s = onehot2(grant_idx_s);
            end else begin
               req_ready_s = 2'b00;
            end
         end
         ST_EXEC: begin
            capture_s = 1'b1;
         end
         ST_RESP: begin
            release_s = rsp_ready[grant_id_r];
         end
         default: begin
            accept_s    = 1'b0;
            capture_s   = 1'b0;
            release_s   = 1'b0;
            req_ready_s = 2'b00;
         end
      endcase
   end

   // Ownership, round-robin history and chain lock, all updated on accept.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         grant_id_r    <= 1'b0;
         last_grant_r  <= 1'b1;
         lock_active_r <= 1'b0;
         lock_owner_r  <= 1'b0;
      end else if (accept_s) begin
         grant_id_r    <= grant_idx_s;
         last_grant_r  <= grant_idx_s;
         // A chained op keeps the ALU for its requester; an unchained one frees it.
         lock_active_r <= req_op_s.chain;
         lock_owner_r  <= grant_idx_s;
      end else begin
         grant_id_r    <= grant_id_r;
         last_grant_r  <= last_grant_r;
         lock_active_r <= lock_active_r;
         lock_owner_r  <= lock_owner_r;
      end
   end

   // Latched operation; cleared on release so the ALU sees zeros while idle.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         op_r <= '0;
      end else if (accept_s) begin
         op_r <= req_op_s;
      end else if (release_s) begin
         op_r <= '0;
      end else begin
         op_r <= op_r;
      end
   end

   // Response capture at the end of EXEC and valid drop on owner handshake.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         rsp_valid_r  <= 2'b00;
         rsp_result_r <= 32'd0;
         rsp_flags_r  <= 4'd0;
      end else if (capture_s) begin
         rsp_valid_r  <= onehot2(grant_id_r);
         rsp_result_r <= alu_result;
         rsp_flags_r  <= alu_flags;
      end else if (release_s) begin
         rsp_valid_r  <= 2'b00;
         rsp_result_r <= rsp_result_r;
         rsp_flags_r  <= rsp_flags_r;
      end else begin
         rsp_valid_r  <= rsp_valid_r;
         rsp_result_r <= rsp_result_r;
         rsp_flags_r  <= rsp_flags_r;
      end
   end

   // Busy mirrors the upcoming state so it is a plain register output.
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != ST_IDLE);
      end
   end

   assign req_ready     = req_ready_s;
   assign alu_src_a     = op_r.src_a;
   assign alu_src_b     = op_r.src_b;
   assign alu_control   = op_r.control;
   assign alu_carry     = op_r.carry;
   assign alu_carry_use = op_r.carry_use;
   assign alu_reverse_b = op_r.reverse_b;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_result    = rsp_result_r;
   assign rsp_flags     = rsp_flags_r;
   assign grant_id      = grant_id_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter: a round-robin instance (dut) and a fixed
// priority instance (dut_fx) share stimulus; each has its own bench-side ALU.
// Expected responses are queued when an op is presented and popped when the
// round-robin instance raises rsp_valid.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        Reset_n;
   logic [1:0]  req_valid, req_carry, req_carry_use, req_reverse_b, req_chain, rsp_ready;
   logic [63:0] req_src_a, req_src_b;
   logic [5:0]  req_alu_control;

   logic [1:0]  req_ready, rsp_valid;
   logic [31:0] alu_src_a, alu_src_b, alu_result, rsp_result;
   logic [2:0]  alu_control;
   logic        alu_carry, alu_carry_use, alu_reverse_b, grant_id, busy;
   logic [3:0]  alu_flags, rsp_flags;

   logic [1:0]  fx_req_ready, fx_rsp_valid;
   logic [31:0] fx_alu_src_a, fx_alu_src_b, fx_alu_result, fx_rsp_result;
   logic [2:0]  fx_alu_control;
   logic        fx_alu_carry, fx_alu_carry_use, fx_alu_reverse_b, fx_grant_id, fx_busy;
   logic [3:0]  fx_alu_flags, fx_rsp_flags;

   typedef struct packed {
      logic        id;
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference ALU: 000 add(+carry), 001 and, 010 or, 011 xor, others zero.
   function automatic logic [35:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic c,
                                          input logic cu, input logic rv);
      logic [31:0] bb;
      logic [32:0] sum;
      logic [31:0] res;
      logic        cf, vf;
      bb  = rv ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {32'd0, (cu & c)};
      cf  = 1'b0;
      vf  = 1'b0;
      case (op)
         3'b000: begin
            res = sum[31:0];
            cf  = sum[32];
            vf  = (a[31] == bb[31]) && (res[31] != a[31]);
         end
         3'b001:  res = a & bb;
         3'b010:  res = a | bb;
         3'b011:  res = a ^ bb;
         default: res = 32'd0;
      endcase
      return {res[31], (res == 32'd0), cf, vf, res};
   endfunction

   assign {alu_flags, alu_result} = alu_fn(alu_control, alu_src_a, alu_src_b,
                                           alu_carry, alu_carry_use, alu_reverse_b);
   assign {fx_alu_flags, fx_alu_result} = alu_fn(fx_alu_control, fx_alu_src_a, fx_alu_src_b,
                                                 fx_alu_carry, fx_alu_carry_use, fx_alu_reverse_b);

   alu_arbiter #(.PRIO_FIXED(1'b0)) dut (
      .CLK(CLK), .Reset_n(Reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src_a(req_src_a), .req_src_b(req_src_b), .req_alu_control(req_alu_control),
      .req_carry(req_carry), .req_carry_use(req_carry_use),
      .req_reverse_b(req_reverse_b), .req_chain(req_chain),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .alu_carry(alu_carry), .alu_carry_use(alu_carry_use), .alu_reverse_b(alu_reverse_b),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .grant_id(grant_id), .busy(busy)
   );

   alu_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
      .CLK(CLK), .Reset_n(Reset_n),
      .req_valid(req_valid), .req_ready(fx_req_ready),
      .req_src_a(req_src_a), .req_src_b(req_src_b), .req_alu_control(req_alu_control),
      .req_carry(req_carry), .req_carry_use(req_carry_use),
      .req_reverse_b(req_reverse_b), .req_chain(req_chain),
      .alu_src_a(fx_alu_src_a), .alu_src_b(fx_alu_src_b), .alu_control(fx_alu_control),
      .alu_carry(fx_alu_carry), .alu_carry_use(fx_alu_carry_use), .alu_reverse_b(fx_alu_reverse_b),
      .alu_result(fx_alu_result), .alu_flags(fx_alu_flags),
      .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(fx_rsp_result), .rsp_flags(fx_rsp_flags),
      .grant_id(fx_grant_id), .busy(fx_busy)
   );

   function automatic logic [1:0] oh(input int i);
      return (i == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int idx, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic c, input logic cu,
                        input logic rv, input logic ch);
      req_valid[idx]              = 1'b1;
      req_alu_control[3*idx +: 3] = op;
      req_src_a[32*idx +: 32]     = a;
      req_src_b[32*idx +: 32]     = b;
      req_carry[idx]              = c;
      req_carry_use[idx]          = cu;
      req_reverse_b[idx]          = rv;
      req_chain[idx]              = ch;
   endtask

   task automatic drop(input int idx);
      req_valid[idx] = 1'b0;
   endtask

   // Compare the current response against the oldest queued expectation.
   task automatic expect_rsp(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, 36'(sb.size() != 0), 36'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_rsp_valid"}, 36'(rsp_valid), 36'(oh(int'(e.id))));
         chk({tag, "_rsp_result"}, 36'(rsp_result), 36'(e.res));
         chk({tag, "_rsp_flags"}, 36'(rsp_flags), 36'(e.flg));
         chk({tag, "_grant_id"}, 36'(grant_id), 36'(e.id));
      end
   endtask

   // Single op from one requester with rsp_ready held high; ends in IDLE.
   task automatic run_op(input string tag, input int idx, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic cu, input logic rv, input logic ch,
                         input logic [31:0] er, input logic [3:0] ef);
      drive(idx, op, a, b, c, cu, rv, ch);
      #1;
      chk({tag, "_ready"}, 36'(req_ready), 36'(oh(idx)));
      sb.push_back('{(idx == 1), er, ef});
      tick();
      drop(idx);
      #1;
      chk({tag, "_exec_ready"}, 36'(req_ready), 36'd0);
      chk({tag, "_exec_op"}, 36'(alu_control), 36'(op));
      tick();
      expect_rsp(tag);
      tick();
   endtask

   initial begin
      Reset_n         = 1'b0;
      req_valid       = 2'b00;
      req_src_a       = 64'd0;
      req_src_b       = 64'd0;
      req_alu_control = 6'd0;
      req_carry       = 2'b00;
      req_carry_use   = 2'b00;
      req_reverse_b   = 2'b00;
      req_chain       = 2'b00;
      rsp_ready       = 2'b11;
      tick();
      tick();

      // Reset state
      chk("rst_busy", 36'(busy), 36'd0);
      chk("rst_rsp_valid", 36'(rsp_valid), 36'd0);
      chk("rst_rsp_result", 36'(rsp_result), 36'd0);
      chk("rst_rsp_flags", 36'(rsp_flags), 36'd0);
      chk("rst_grant_id", 36'(grant_id), 36'd0);
      chk("rst_alu_src_a", 36'(alu_src_a), 36'd0);
      Reset_n = 1'b1;

      // ADD 5+7 from requester 0: exact t+1 / t+2 timing
      drive(0, 3'b000, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("add_ready", 36'(req_ready), 36'h1);
      sb.push_back('{1'b0, 32'd12, 4'b0000});
      tick();
      drop(0);
      #1;
      chk("add_exec_busy", 36'(busy), 36'd1);
      chk("add_exec_src_a", 36'(alu_src_a), 36'd5);
      chk("add_exec_src_b", 36'(alu_src_b), 36'd7);
      chk("add_exec_rsp_valid", 36'(rsp_valid), 36'd0);
      tick();
      expect_rsp("add");
      tick();
      chk("add_idle_busy", 36'(busy), 36'd0);
      chk("add_idle_src_a", 36'(alu_src_a), 36'd0);
      chk("add_idle_rsp_valid", 36'(rsp_valid), 36'd0);

      // Both valid every cycle: round-robin 0,1,0,1 vs fixed 0,0,0,0
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      drive(0, 3'b000, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1, 3'b000, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_ready", 36'(req_ready), 36'(oh(k % 2)));
         chk("fx_ready", 36'(fx_req_ready), 36'h1);
         sb.push_back('{((k % 2) == 1), ((k % 2) == 1) ? 32'd30 : 32'd3, 4'b0000});
         tick();
         chk("rr_exec_ready", 36'(req_ready), 36'd0);
         tick();
         expect_rsp("rr");
         chk("fx_rsp_valid", 36'(fx_rsp_valid), 36'h1);
         chk("fx_rsp_result", 36'(fx_rsp_result), 36'd3);
         tick();
      end
      drop(0);
      drop(1);

      // Chained lock by requester 1; requester 0 stalls until unlocked
      drive(1, 3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("lk1_ready", 36'(req_ready), 36'h2);
      sb.push_back('{1'b1, 32'd0, 4'b0110});
      tick();
      drop(1);
      drive(0, 3'b000, 32'd10, 32'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      chk("lk1_exec_ready", 36'(req_ready), 36'd0);
      tick();
      expect_rsp("lk1");
      tick();
      chk("lk_stall_ready", 36'(req_ready), 36'd0);
      chk("lk_stall_busy", 36'(busy), 36'd0);
      tick();
      chk("lk_stall2_ready", 36'(req_ready), 36'd0);
      run_op("lk2", 1, 3'b000, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 4'b0000);
      chk("unlock_ready", 36'(req_ready), 36'h1);
      sb.push_back('{1'b0, 32'd7, 4'b0010});
      tick();
      drop(0);
      #1;
      chk("unlock_exec_rev", 36'(alu_reverse_b), 36'd1);
      chk("unlock_exec_carry", 36'(alu_carry), 36'd1);
      tick();
      expect_rsp("unlock");
      tick();

      // Response held with rsp_ready low (and non-owner ready ignored)
      rsp_ready = 2'b00;
      drive(0, 3'b001, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("hold_ready", 36'(req_ready), 36'h1);
      sb.push_back('{1'b0, 32'h0000_F000, 4'b0000});
      tick();
      drive(1, 3'b000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("hold_exec_ready", 36'(req_ready), 36'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("hold_rsp_valid", 36'(rsp_valid), 36'h1);
         chk("hold_rsp_result", 36'(rsp_result), 36'h0000_F000);
         chk("hold_req_ready", 36'(req_ready), 36'd0);
         if (i >= 2) begin
            rsp_ready = 2'b10;
         end
         tick();
      end
      req_valid = 2'b00;
      rsp_ready = 2'b01;
      expect_rsp("hold");
      tick();
      chk("hold_idle_busy", 36'(busy), 36'd0);
      rsp_ready = 2'b11;

      // Reset during EXEC discards the op
      drive(0, 3'b000, 32'd100, 32'd200, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drop(0);
      #1;
      chk("rexec_busy", 36'(busy), 36'd1);
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      chk("rexec_busy_after", 36'(busy), 36'd0);
      chk("rexec_rsp_result", 36'(rsp_result), 36'd0);
      chk("rexec_alu_src_a", 36'(alu_src_a), 36'd0);
      for (int i = 0; i < 3; i++) begin
         chk("rexec_rsp_valid", 36'(rsp_valid), 36'd0);
         tick();
      end

      // Pass-through opcodes and other logic ops
      run_op("op7", 1, 3'b111, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0, 1'b0, 1'b0,
             32'd0, 4'b0100);
      run_op("op6", 0, 3'b110, 32'h0000_AAAA, 32'h0000_5555, 1'b1, 1'b1, 1'b0, 1'b0,
             32'd0, 4'b0100);
      run_op("or", 0, 3'b010, 32'h0000_0F00, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h0000_0FF0, 4'b0000);
      run_op("xor", 1, 3'b011, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0,
             32'h8000_0000, 4'b1000);

      chk("sb_empty", 36'(sb.size()), 36'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
